// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the 16-bit calculator datapath: one command at a time,
// single-cycle bitwise/add/sub, 16-cycle shift-add multiply, chained answer accumulator.
module calc_op_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [PW-1:0]      p_sum;
    logic               mul_last;

    assign cap_a    = use_acc ? acc_q : a;
    assign add_full = {1'b0, opa_q} + {1'b0, opb_q};
    // Top bit of the widened difference is the borrow (opa < opb).
    assign sub_full = {1'b0, opa_q} - {1'b0, opb_q};
    assign p_sum    = p_q + (mplier_q[0] ? mcand_q : PW'(0));
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_d = S_DONE;
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    opa_d    = cap_a;
                    opb_d    = b;
                    mcand_d  = PW'(cap_a);
                    mplier_d = b;
                    p_d      = '0;
                    cnt_d    = '0;
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_NOT: begin result_d = ~opa_q;          ovf_d = 1'b0;             end
                    OP_AND: begin result_d = opa_q & opb_q;   ovf_d = 1'b0;             end
                    OP_OR:  begin result_d = opa_q | opb_q;   ovf_d = 1'b0;             end
                    OP_XOR: begin result_d = opa_q ^ opb_q;   ovf_d = 1'b0;             end
                    OP_ADD: begin result_d = add_full[WIDTH-1:0]; ovf_d = add_full[WIDTH]; end
                    OP_SUB: begin result_d = sub_full[WIDTH-1:0]; ovf_d = sub_full[WIDTH]; end
                    OP_CLR: begin result_d = '0;              ovf_d = 1'b0;             end
                    default: begin result_d = '0;             ovf_d = 1'b0;             end
                endcase
                acc_d = result_d;
            end
            S_MUL: begin
                p_d      = p_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (mul_last) begin
                    result_d = p_sum[WIDTH-1:0];
                    ovf_d    = |p_sum[PW-1:WIDTH];
                    acc_d    = p_sum[WIDTH-1:0];
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
    assign acc      = acc_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed, table-driven bench for calc_op_sequencer plus hand-written
// sequences for held start during multiply and reset mid-multiply.
module tb_calc_op_sequencer;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic [15:0] acc;

    int checks = 0;
    int errors = 0;

    calc_op_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .use_acc  (use_acc),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .acc      (acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        use_acc;
        logic [15:0] res;
        logic        ovf;
        logic [15:0] acc;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the command has retired.
    task automatic run_cmd(input string name, input logic [2:0] c_op, input logic [15:0] c_a,
                           input logic [15:0] c_b, input logic c_ua, input logic [15:0] e_res,
                           input logic e_ovf, input logic [15:0] e_acc, input int e_lat);
        int n;
        start   = 1'b1;
        op      = c_op;
        a       = c_a;
        b       = c_b;
        use_acc = c_ua;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        op      = c_op ^ 3'b001;
        a       = ~c_a;
        b       = ~c_b;
        use_acc = ~c_ua;
        check({name, ".busy_after_e0"}, 32'(busy), 32'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done) break;
        end
        check({name, ".latency"}, 32'(n), 32'(e_lat));
        check({name, ".result"}, 32'(result), 32'(e_res));
        check({name, ".overflow"}, 32'(overflow), 32'(e_ovf));
        check({name, ".acc"}, 32'(acc), 32'(e_acc));
        @(posedge clk);
        @(negedge clk);
        check({name, ".done_clear"}, 32'(done), 32'd0);
        check({name, ".busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{OP_NOT, 16'h00F0, 16'h1234, 1'b0, 16'hFF0F, 1'b0, 16'hFF0F, 1};
        vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0000, 1};
        vecs[2]  = '{OP_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 16'hFFFE, 1};
        vecs[3]  = '{OP_MUL, 16'd300,  16'd200,  1'b0, 16'hEA60, 1'b0, 16'hEA60, 16};
        vecs[4]  = '{OP_MUL, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 16'h0000, 16};
        vecs[5]  = '{OP_ADD, 16'd5,    16'd7,    1'b0, 16'h000C, 1'b0, 16'h000C, 1};
        vecs[6]  = '{OP_MUL, 16'hDEAD, 16'd3,    1'b1, 16'h0024, 1'b0, 16'h0024, 16};
        vecs[7]  = '{OP_CLR, 16'h5555, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 16'h0000, 1};
        vecs[8]  = '{OP_XOR, 16'hFF00, 16'h0FF0, 1'b0, 16'hF0F0, 1'b0, 16'hF0F0, 1};
        vecs[9]  = '{OP_OR,  16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 16'h1234, 1};
        vecs[10] = '{OP_SUB, 16'h9999, 16'h0234, 1'b1, 16'h1000, 1'b0, 16'h1000, 1};
        vecs[11] = '{OP_SUB, 16'd5,    16'd5,    1'b0, 16'h0000, 1'b0, 16'h0000, 1};
        vecs[12] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 16'h0001, 16};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.acc", 32'(acc), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc,
                    vecs[i].res, vecs[i].ovf, vecs[i].acc, vecs[i].lat);
        end

        // Start held high through a multiply while op/a/b keep changing.
        start = 1'b1; op = OP_MUL; a = 16'd7; b = 16'd9; use_acc = 1'b0;
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (n == 0) check("hold.busy_after_e0", 32'(busy), 32'd1);
            if (n == 8) begin
                check("hold.result_stable", 32'(result), 32'h0001);
                check("hold.ovf_stable", 32'(overflow), 32'd1);
            end
            if (done) break;
            op = 3'((n % 6));
            a  = 16'($urandom);
            b  = 16'($urandom);
            @(posedge clk);
            n++;
        end
        check("hold.latency", 32'(n), 32'd16);
        check("hold.result", 32'(result), 32'h003F);
        check("hold.overflow", 32'(overflow), 32'd0);
        check("hold.acc", 32'(acc), 32'h003F);
        op = OP_XOR; a = 16'h1111; b = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        check("hold.idle_e17.busy", 32'(busy), 32'd0);
        check("hold.idle_e17.done", 32'(done), 32'd0);
        op = OP_AND; a = 16'hF0F0; b = 16'hFF00;
        @(posedge clk);
        @(negedge clk);
        check("hold.second_accept_e18", 32'(busy), 32'd1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold.second_done", 32'(done), 32'd1);
        check("hold.second_result", 32'(result), 32'hF000);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        start = 1'b1; op = OP_MUL; a = 16'd300; b = 16'd200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("midmul.busy_before", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b1; op = OP_AND; a = 16'h0001; b = 16'h0001;
        #1;
        check("midmul.busy", 32'(busy), 32'd0);
        check("midmul.done", 32'(done), 32'd0);
        check("midmul.result", 32'(result), 32'd0);
        check("midmul.overflow", 32'(overflow), 32'd0);
        check("midmul.acc", 32'(acc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midmul.no_accept_in_rst", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midmul.idle_after_release", 32'(busy), 32'd0);
        run_cmd("post_rst_and", OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 16'h3030, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Operation sequencer for the 16-bit scientific calculator datapath. Accepts one command at a time (opcode plus two operands) through a start/busy/done handshake. Executes bitwise operations (including the 16-bit inverter) and add/subtract in one execute cycle, and multiply as a 16-cycle shift-add iteration. Keeps an answer accumulator so the keypad/display front end can chain operations on the previous result.

## Interface
- WIDTH, 16: operand/result width; all arithmetic rules below assume 16.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- op  in  3  opcode: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 CLR.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored by NOT and CLR).
- use_acc  in  1  when 1, the current acc value replaces a at command capture.
- busy  out  1  high in every state except IDLE.
- done  out  1  high exactly one cycle (DONE state).
- result  out  WIDTH  last result; held until the next DONE.
- overflow  out  1  status of last result; held with result.
- acc  out  WIDTH  answer accumulator.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE with start=1 at an edge:
  - Capture op, opA (a, or acc if use_acc=1), and opB.
  - Go to MUL if op=6, else go to EXEC.
- IDLE with start=0: stay in IDLE.
- EXEC (one cycle): register result and overflow, write acc <= result, go to DONE.
  - NOT: ~opA, ovf 0.
  - AND/OR/XOR: bitwise, ovf 0.
  - ADD: low 16 bits of opA+opB, ovf = carry out.
  - SUB: opA−opB mod 2^16, ovf = borrow (opA<opB).
  - CLR: result 0, ovf 0, acc 0.
- MUL: 32-bit product register P (cleared at capture), multiplicand shifted left, multiplier shifted right, 5-bit counter.
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand into P. Counter increments.
  - After the 16th MUL edge: result = P[15:0], ovf = (P[31:16] != 0), acc <= result, go to DONE.
- DONE: done=1, busy=1. Next edge goes to IDLE.
- start is ignored whenever state != IDLE. No queuing: a command presented while busy is dropped. The requester must hold start until it sees busy rise.
- Inputs a/b/op/use_acc may change after capture without effect.
- Unsigned arithmetic only. No sign handling.

## Timing
- Reset (async assert, in any state including mid-MUL):
  - state IDLE.
  - busy 0, done 0, result 0, overflow 0, acc 0.
  - P and counter 0.
  - The in-flight command is discarded.
- Release is synchronous to the next clk edge. start must not be accepted on the edge where rst is high.
- Capture edge is E0.
- Single-cycle ops:
  - busy=1 after E0.
  - result/overflow/acc valid and done=1 after E1.
  - busy=0 after E2.
  - Next start accepted at E3 earliest (3-cycle issue interval).
- MUL:
  - busy=1 after E0.
  - done=1 and result valid after E16.
  - IDLE after E17.
  - Next start accepted at E18 earliest.
- result/overflow change only on the edge entering DONE. They are stable at all other times, including during MUL.
- use_acc reads acc as registered before E0. Chaining back-to-back uses the result of the previous DONE.

## Test plan
- Reset, then NOT with a=0x00F0, start at E0 → after E1: done=1, result=0xFF0F, overflow=0, acc=0xFF0F. After E2: done=0, busy=0.
- ADD a=0xFFFF, b=0x0001 → result 0x0000, overflow=1. Then SUB a=0x0003, b=0x0005 → result 0xFFFE, overflow=1.
- MUL a=300, b=200 → done after exactly 16 MUL edges (after E16), result 0xEA60, overflow=0. MUL a=0x0100, b=0x0100 → result 0x0000, overflow=1.
- Chaining: ADD 5+7 (acc=12), then MUL use_acc=1 with b=3 → result 36. Then CLR → acc 0.
- Hold start high throughout a MUL with a different op/a/b changing each cycle → exactly one command executes, with the operands captured at E0. A second command is accepted only when IDLE (E18).
- Assert rst at MUL cycle 8 → outputs immediately at reset values (busy 0, acc 0). After release, an AND 0xF0F0 & 0x3C3C → result 0x3030.
